// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war player input path.
package tug_pkg;

    // Simulation-friendly debounce length; the hardware build overrides it.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Default width of each per-player press counter.
    localparam int DEFAULT_CNT_W = 8;

    typedef logic [DEFAULT_CNT_W-1:0] press_cnt_t;

    // Button levels after inversion, shared with the light cells.
    localparam logic LEVEL_ACTIVE = 1'b1;
    localparam logic LEVEL_IDLE   = 1'b0;

    // Debounce counter width: clog2 of the run length, never below one bit.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/tug_key_debounce.sv
// One button channel: inversion, two-flop synchronizer, run-length debounce
// and a rise-event strobe that is high during the cycle whose closing edge
// accepts a new pressed level.
module tug_key_debounce
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic Reset,
    input  logic key_n_i,
    output logic rise_o
);

    localparam int             CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Next-state for the accepted level and the disagreement run counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
        if (accept) begin
            stable_d = sync2_q;
        end else if (sync2_q != stable_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Only an accepted 0->1 transition is a press; a release is silent.
    assign rise_o = accept && (sync2_q == LEVEL_ACTIVE);

    // Synchronizer and debounce state; reset treats the key as already pressed
    // so a button held through reset release never produces a press.
    always_ff @(posedge clk) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1_q  <= LEVEL_ACTIVE;
            sync2_q  <= LEVEL_ACTIVE;
            stable_q <= LEVEL_ACTIVE;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= ~key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tug_key_input.sv
// Player-input front end: two debounced button channels, game-over gating,
// registered single-cycle L/R move pulses and saturating press counters.
module tug_key_input
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             key_l_n,
    input  logic             key_r_n,
    input  logic             freeze,
    output logic             L,
    output logic             R,
    output logic [CNT_W-1:0] l_count,
    output logic [CNT_W-1:0] r_count
);

    logic             rise_l;
    logic             rise_r;
    logic             emit_l;
    logic             emit_r;
    logic             l_q;
    logic             r_q;
    logic [CNT_W-1:0] l_count_q;
    logic [CNT_W-1:0] l_count_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] r_count_d;

    tug_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_l (
        .clk     (clk),
        .Reset   (Reset),
        .key_n_i (key_l_n),
        .rise_o  (rise_l)
    );

    tug_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_r (
        .clk     (clk),
        .Reset   (Reset),
        .key_n_i (key_r_n),
        .rise_o  (rise_r)
    );

    // A press accepted while frozen is consumed: no pulse and no count.
    assign emit_l = rise_l && !freeze;
    assign emit_r = rise_r && !freeze;

    // Saturating press counters: stop at all-ones instead of wrapping.
    always_comb begin
        l_count_d = l_count_q;
        r_count_d = r_count_q;
        if (emit_l && (l_count_q != '1)) begin
            l_count_d = l_count_q + 1'b1;
        end
        if (emit_r && (r_count_q != '1)) begin
            r_count_d = r_count_q + 1'b1;
        end
    end

    // Move pulses and counters; a pending pulse is dropped by reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            l_q       <= 1'b0;
            r_q       <= 1'b0;
            l_count_q <= '0;
            r_count_q <= '0;
        end else begin
            l_q       <= emit_l;
            r_q       <= emit_r;
            l_count_q <= l_count_d;
            r_count_q <= r_count_d;
        end
    end

    assign L       = l_q;
    assign R       = r_q;
    assign l_count = l_count_q;
    assign r_count = r_count_q;

endmodule

// File: tb/tb_tug_key_input.sv
// Self-checking bench for tug_key_input: directed scenarios plus random
// button/freeze/reset activity, compared every cycle against a window-based
// reference model of the button channels.
module tb_tug_key_input;

    localparam int DB    = 4;
    localparam int CW    = 8;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk;
    logic          Reset;
    logic          key_l_n;
    logic          key_r_n;
    logic          freeze;
    logic          L;
    logic          R;
    logic [CW-1:0] l_count;
    logic [CW-1:0] r_count;

    int n_checks;
    int n_fail;
    int l_pulses;
    int r_pulses;

    // Reference model state, index 0 = left, 1 = right.
    int m_s1   [2];
    int m_s2   [2];
    int m_acc  [2];
    int m_hist [2][DB];
    int m_out  [2];
    int m_cnt  [2];

    tug_key_input #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk     (clk),
        .Reset   (Reset),
        .key_l_n (key_l_n),
        .key_r_n (key_r_n),
        .freeze  (freeze),
        .L       (L),
        .R       (R),
        .l_count (l_count),
        .r_count (r_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock edge of the model. A level is accepted once the last DB
    // synchronized samples all disagree with the accepted level.
    task automatic model_edge(input bit rst, input bit fr, input bit pl, input bit pr);
        bit press [2];
        press[0] = pl;
        press[1] = pr;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_s1[c]  = 1;
                m_s2[c]  = 1;
                m_acc[c] = 1;
                for (int i = 0; i < DB; i++) m_hist[c][i] = 1;
                m_out[c] = 0;
                m_cnt[c] = 0;
            end else begin
                bit all_diff;
                bit rise;
                for (int i = DB - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
                m_hist[c][0] = m_s2[c];
                all_diff = 1'b1;
                for (int i = 0; i < DB; i++) if (m_hist[c][i] == m_acc[c]) all_diff = 1'b0;
                rise = 1'b0;
                if (all_diff) begin
                    rise     = (m_acc[c] == 0);
                    m_acc[c] = 1 - m_acc[c];
                end
                m_out[c] = (rise && !fr) ? 1 : 0;
                if (m_out[c] == 1 && m_cnt[c] < MAXC) m_cnt[c]++;
                m_s2[c] = m_s1[c];
                m_s1[c] = press[c];
            end
        end
    endtask

    // Advance one edge, update the model and compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge(Reset, freeze, !key_l_n, !key_r_n);
        #1;
        check("L", L, m_out[0]);
        check("R", R, m_out[1]);
        check("l_count", l_count, m_cnt[0]);
        check("r_count", r_count, m_cnt[1]);
        if (L) l_pulses++;
        if (R) r_pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        ticks(3);
        Reset = 1'b0;
        l_pulses = 0;
        r_pulses = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        l_pulses = 0;
        r_pulses = 0;
        Reset    = 1'b1;
        key_l_n  = 1'b1;
        key_r_n  = 1'b1;
        freeze   = 1'b0;

        // Reset state, then released keys settle silently.
        reset_dut();
        check("reset_l_count", l_count, 0);
        check("reset_r_count", r_count, 0);
        ticks(10);

        // Left press latency: pulse only in the cycle after edge k+5.
        key_l_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("lat_L", L, (i == 5) ? 1 : 0);
            check("lat_R", R, 0);
        end
        key_l_n = 1'b1;
        ticks(10);
        check("press_l_count", l_count, 1);

        // Glitch of 3 cycles is discarded; 4 cycles is a press.
        key_r_n = 1'b0;
        ticks(3);
        key_r_n = 1'b1;
        ticks(10);
        check("glitch_r_pulses", r_pulses, 0);
        check("glitch_r_count", r_count, 0);
        key_r_n = 1'b0;
        ticks(4);
        key_r_n = 1'b1;
        ticks(10);
        check("min_r_pulses", r_pulses, 1);
        check("min_r_count", r_count, 1);

        // Simultaneous presses pulse both outputs together.
        reset_dut();
        ticks(10);
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("both_same", L, R);
        end
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        ticks(10);
        check("both_l_pulses", l_pulses, 1);
        check("both_r_pulses", r_pulses, 1);
        check("both_l_count", l_count, 1);
        check("both_r_count", r_count, 1);

        // Press during freeze is consumed even after freeze drops.
        reset_dut();
        ticks(10);
        freeze  = 1'b1;
        key_l_n = 1'b0;
        ticks(10);
        freeze  = 1'b0;
        ticks(10);
        check("frz_l_pulses", l_pulses, 0);
        check("frz_l_count", l_count, 0);
        key_l_n = 1'b1;
        ticks(10);
        key_l_n = 1'b0;
        ticks(10);
        key_l_n = 1'b1;
        ticks(10);
        check("frz_after_pulses", l_pulses, 1);
        check("frz_after_count", l_count, 1);

        // Key held through reset produces nothing until re-pressed.
        key_l_n = 1'b0;
        reset_dut();
        ticks(15);
        check("hold_rst_pulses", l_pulses, 0);
        key_l_n = 1'b1;
        ticks(10);
        key_l_n = 1'b0;
        ticks(10);
        key_l_n = 1'b1;
        ticks(10);
        check("hold_rst_after", l_pulses, 1);

        // 260 clean presses: every press pulses, counter saturates.
        reset_dut();
        ticks(10);
        for (int p = 0; p < 260; p++) begin
            key_l_n = 1'b0;
            ticks(6);
            key_l_n = 1'b1;
            ticks(6);
        end
        check("sat_pulses", l_pulses, 260);
        check("sat_count", l_count, MAXC);

        // Random buttons, freeze and occasional reset against the model.
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) key_l_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) key_r_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) freeze = ~freeze;
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset   = 1'b0;
        freeze  = 1'b0;
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
